// File: rtl/fir_pkg.sv
// Shared FIR constants, loader state encoding and sizing helper.
package fir_pkg;

   localparam int unsigned DEF_NUM_TAPS     = 71;
   localparam int unsigned DEF_COEFF_W      = 8;
   localparam int unsigned DEF_ADDR_W       = 7;
   localparam int unsigned DEF_SAMPLE_W     = 4;
   localparam int unsigned DEF_FLUSH_CYCLES = 150;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_READY = 2'd3
   } fir_state_e;

   // Bits needed to hold the value n (at least one bit).
   function automatic int unsigned bits_for(input int unsigned n);
      bits_for = (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Coefficient stream handshake between a source and the loader.
interface fir_coeff_loader_if
   import fir_pkg::*;
#(
   parameter int unsigned COEFF_W = DEF_COEFF_W
);
   logic                      s_valid;
   logic signed [COEFF_W-1:0] s_data;
   logic                      s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fir_flush_timer.sv
// Loadable count-down timer; expire_c is high in the last enabled cycle.
module fir_flush_timer
   import fir_pkg::*;
#(
   parameter int unsigned CYCLES = DEF_FLUSH_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expire_c
);
   localparam int unsigned CNT_W = bits_for(CYCLES);

   logic [CNT_W-1:0] cnt;

   // Reload on request, otherwise count down while enabled until zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CNT_W'(CYCLES);
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expire_c = en && (cnt == CNT_W'(1));
endmodule

// File: rtl/fir_coeff_loader.sv
// Streams NUM_TAPS coefficients into the filter, waits for the pipeline
// to flush, then gates samples through and flags the filter ready.
module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter int unsigned NUM_TAPS     = DEF_NUM_TAPS,
   parameter int unsigned COEFF_W      = DEF_COEFF_W,
   parameter int unsigned ADDR_W       = DEF_ADDR_W,
   parameter int unsigned SAMPLE_W     = DEF_SAMPLE_W,
   parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   fir_coeff_loader_if.slave          s_bus,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   output logic                       coeff_write,
   output logic [ADDR_W-1:0]          coeff_addr,
   output logic signed [COEFF_W-1:0]  coeff_in,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic                       filt_ready,
   output logic                       done
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);

   fir_state_e        state;
   logic [ADDR_W-1:0] addr_cnt;
   logic              accept_c;
   logic              last_beat_c;
   logic              flush_en_c;
   logic              flush_done_c;

   // A beat coincident with start is swallowed without a write.
   assign accept_c    = (state == ST_LOAD) && s_bus.s_valid && s_bus.s_ready && !start;
   assign last_beat_c = accept_c && (addr_cnt == LAST_ADDR);
   assign flush_en_c  = (state == ST_FLUSH);

   fir_flush_timer #(.CYCLES(FLUSH_CYCLES)) u_flush_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (last_beat_c),
      .en       (flush_en_c),
      .expire_c (flush_done_c)
   );

   // Load sequencer with registered handshake, write port and sample gate.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         addr_cnt      <= '0;
         s_bus.s_ready <= 1'b0;
         coeff_write   <= 1'b0;
         coeff_addr    <= '0;
         coeff_in      <= '0;
         sample_out    <= '0;
         filt_ready    <= 1'b0;
         done          <= 1'b0;
      end else begin
         coeff_write <= 1'b0;
         done        <= 1'b0;
         sample_out  <= ((state == ST_READY) && !start) ? sample_in : '0;

         if (start) begin
            state         <= ST_LOAD;
            addr_cnt      <= '0;
            s_bus.s_ready <= 1'b1;
            filt_ready    <= 1'b0;
         end else begin
            case (state)
               ST_LOAD: begin
                  if (accept_c) begin
                     coeff_write <= 1'b1;
                     coeff_addr  <= addr_cnt;
                     coeff_in    <= s_bus.s_data;
                     if (last_beat_c) begin
                        state         <= ST_FLUSH;
                        s_bus.s_ready <= 1'b0;
                     end else begin
                        addr_cnt <= addr_cnt + ADDR_W'(1);
                     end
                  end
               end
               ST_FLUSH: begin
                  if (flush_done_c) begin
                     state      <= ST_READY;
                     filt_ready <= 1'b1;
                     done       <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed bench for fir_coeff_loader: load sequences, flush timing,
// restart, sample gating, overflow protection and reset recovery.
module tb_fir_coeff_loader;
   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic signed [3:0] sample_in;
   logic signed [3:0] sample_out;
   logic              coeff_write;
   logic [6:0]        coeff_addr;
   logic signed [7:0] coeff_in;
   logic              filt_ready;
   logic              done;

   int checks = 0;
   int errors = 0;

   fir_coeff_loader_if #(.COEFF_W(8)) bus ();

   fir_coeff_loader dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .s_bus       (bus),
      .sample_in   (sample_in),
      .coeff_write (coeff_write),
      .coeff_addr  (coeff_addr),
      .coeff_in    (coeff_in),
      .sample_out  (sample_out),
      .filt_ready  (filt_ready),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Write/done logger; sees the values of the cycle that just ended.
   int         cyc    = 0;
   logic       mon_en = 1'b0;
   int         nz     = 0;
   int         done_n = 0;
   int         done_c = 0;
   logic [6:0] wa[$];
   logic [7:0] wd[$];
   int         wc[$];

   always @(posedge clk) begin
      if (mon_en) begin
         if (coeff_write === 1'b1) begin
            wa.push_back(coeff_addr);
            wd.push_back(coeff_in);
            wc.push_back(cyc);
         end
         if (done === 1'b1) begin
            done_n++;
            done_c = cyc;
         end
         if (filt_ready !== 1'b1 && sample_out !== 4'h0) nz++;
      end
      cyc++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      wc.delete();
      done_n = 0;
      nz     = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_beats(input int n);
      for (int i = 0; i < n; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(i);
         tick();
      end
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (filt_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; sample_in = 4'h7;
      tick();
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", bus.s_ready); end
      checks++; if (coeff_write !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", coeff_write); end
      checks++; if (coeff_addr !== 7'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", coeff_addr); end
      checks++; if (coeff_in !== 8'sd0) begin errors++; $display("FAIL reset_data got %0d want 0", coeff_in); end
      checks++; if (sample_out !== 4'sd0) begin errors++; $display("FAIL reset_sample got %h want 0", sample_out); end
      checks++; if (filt_ready !== 1'b0) begin errors++; $display("FAIL reset_filt_ready got %b want 0", filt_ready); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      tick();
      rst = 1'b0;
      mon_en = 1'b1;
      tick();
   endtask

   task automatic test_back_to_back();
      bit ok;
      int p0;
      clear_log();
      sample_in = 4'h5;
      pulse_start();
      p0 = cyc;
      send_beats(71);
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_ready_timeout got 0 want 1"); end
      checks++; if (wa.size() != 71) begin errors++; $display("FAIL b2b_count got %0d want 71", wa.size()); end
      if (wa.size() == 71) begin
         for (int i = 0; i < 71; i++) begin
            checks++;
            if (wa[i] !== 7'(i) || wd[i] !== 8'(i)) begin
               errors++; $display("FAIL b2b_write[%0d] got addr %0d data %0d want %0d", i, wa[i], wd[i], i);
            end
         end
         checks++; if (wc[0] != p0 + 1) begin errors++; $display("FAIL b2b_latency got cycle %0d want %0d", wc[0], p0 + 1); end
         checks++; if (wc[70] != wc[0] + 70) begin errors++; $display("FAIL b2b_contiguous got %0d want %0d", wc[70], wc[0] + 70); end
         checks++; if (done_c != wc[70] + 150) begin errors++; $display("FAIL b2b_done_time got %0d want %0d", done_c, wc[70] + 150); end
      end
      checks++; if (done_n != 1) begin errors++; $display("FAIL b2b_done_pulses got %0d want 1", done_n); end
      checks++; if (filt_ready !== 1'b1) begin errors++; $display("FAIL b2b_filt_ready got %b want 1", filt_ready); end
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL b2b_s_ready got %b want 0", bus.s_ready); end
      checks++; if (nz != 0) begin errors++; $display("FAIL b2b_sample_gate got %0d want 0", nz); end
   endtask

   task automatic test_gaps();
      bit ok;
      int pc[71];
      int gap;
      clear_log();
      pulse_start();
      for (int i = 0; i < 71; i++) begin
         gap = (i % 4 == 1) ? 2 : ((i % 7 == 3) ? 1 : 0);
         for (int g = 0; g < gap; g++) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'hAA;
            tick();
         end
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(i);
         pc[i] = cyc;
         tick();
      end
      bus.s_valid = 1'b0;
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL gap_ready_timeout got 0 want 1"); end
      checks++; if (wa.size() != 71) begin errors++; $display("FAIL gap_count got %0d want 71", wa.size()); end
      if (wa.size() == 71) begin
         for (int i = 0; i < 71; i++) begin
            checks++;
            if (wa[i] !== 7'(i) || wd[i] !== 8'(i) || wc[i] != pc[i] + 1) begin
               errors++; $display("FAIL gap_write[%0d] got addr %0d data %0d cyc %0d want %0d cyc %0d",
                                  i, wa[i], wd[i], wc[i], i, pc[i] + 1);
            end
         end
         checks++; if (done_c != wc[70] + 150) begin errors++; $display("FAIL gap_done_time got %0d want %0d", done_c, wc[70] + 150); end
      end
      checks++; if (done_n != 1) begin errors++; $display("FAIL gap_done_pulses got %0d want 1", done_n); end
      checks++; if (nz != 0) begin errors++; $display("FAIL gap_sample_gate got %0d want 0", nz); end
   endtask

   task automatic test_restart();
      bit ok;
      int ea;
      clear_log();
      pulse_start();
      send_beats(30);
      start = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h7F;
      tick();
      start = 1'b0;
      send_beats(71);
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL restart_ready_timeout got 0 want 1"); end
      checks++; if (wa.size() != 101) begin errors++; $display("FAIL restart_count got %0d want 101", wa.size()); end
      if (wa.size() == 101) begin
         for (int i = 0; i < 101; i++) begin
            ea = (i < 30) ? i : i - 30;
            checks++;
            if (wa[i] !== 7'(ea) || wd[i] !== 8'(ea)) begin
               errors++; $display("FAIL restart_write[%0d] got addr %0d data %0d want %0d", i, wa[i], wd[i], ea);
            end
         end
      end
      checks++; if (done_n != 1) begin errors++; $display("FAIL restart_done_pulses got %0d want 1", done_n); end
   endtask

   task automatic test_samples();
      sample_in = 4'h1;
      tick();
      checks++; if (sample_out !== 4'h1) begin errors++; $display("FAIL sample_1 got %h want 1", sample_out); end
      sample_in = 4'hF;
      tick();
      checks++; if (sample_out !== 4'hF) begin errors++; $display("FAIL sample_f got %h want f", sample_out); end
      start = 1'b1;
      sample_in = 4'h3;
      tick();
      start = 1'b0;
      checks++; if (sample_out !== 4'h0) begin errors++; $display("FAIL sample_on_start got %h want 0", sample_out); end
      checks++; if (filt_ready !== 1'b0) begin errors++; $display("FAIL start_filt_ready got %b want 0", filt_ready); end
      checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL start_s_ready got %b want 1", bus.s_ready); end
   endtask

   task automatic test_overflow();
      bit ok;
      int hi_ready = 0;
      clear_log();
      for (int i = 0; i < 71; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(i);
         tick();
      end
      bus.s_data = 8'h7E;
      for (int k = 0; k < 10; k++) begin
         if (bus.s_ready !== 1'b0) hi_ready++;
         tick();
      end
      checks++; if (hi_ready != 0) begin errors++; $display("FAIL ovf_s_ready got %0d high cycles want 0", hi_ready); end
      bus.s_valid = 1'b0;
      wait_ready(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovf_ready_timeout got 0 want 1"); end
      checks++; if (wa.size() != 71) begin errors++; $display("FAIL ovf_count got %0d want 71", wa.size()); end
      checks++; if (coeff_addr !== 7'd70 || coeff_in !== 8'sd70) begin
         errors++; $display("FAIL ovf_hold got addr %0d data %0d want 70", coeff_addr, coeff_in);
      end
      checks++; if (nz != 0) begin errors++; $display("FAIL ovf_sample_gate got %0d want 0", nz); end
   endtask

   task automatic test_reset_flush();
      clear_log();
      sample_in = 4'h6;
      pulse_start();
      send_beats(71);
      repeat (20) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL rstf_s_ready got %b want 0", bus.s_ready); end
      checks++; if (coeff_write !== 1'b0) begin errors++; $display("FAIL rstf_write got %b want 0", coeff_write); end
      checks++; if (coeff_addr !== 7'd0 || coeff_in !== 8'sd0) begin
         errors++; $display("FAIL rstf_bus got addr %0d data %0d want 0", coeff_addr, coeff_in);
      end
      checks++; if (sample_out !== 4'h0 || filt_ready !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL rstf_outs got %h %b %b want 0", sample_out, filt_ready, done);
      end
      clear_log();
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h11;
      repeat (200) tick();
      bus.s_valid = 1'b0;
      checks++; if (wa.size() != 0) begin errors++; $display("FAIL rstf_writes got %0d want 0", wa.size()); end
      checks++; if (done_n != 0) begin errors++; $display("FAIL rstf_done got %0d want 0", done_n); end
      checks++; if (filt_ready !== 1'b0 || bus.s_ready !== 1'b0) begin
         errors++; $display("FAIL rstf_idle got filt %b s_ready %b want 0", filt_ready, bus.s_ready);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_gaps();
      test_restart();
      test_samples();
      test_overflow();
      test_reset_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
